bit_op_sequencer: RTL

Multi-cycle controller that sequences the bit set/clear datapath for the AVR core. It owns a held copy of the instruction word that the datapath decodes, and runs read-modify-write cycles on the I/O bus for SBI/CBI. It evaluates SBIC/SBIS skip conditions and issues the write strobes for register-file, T-flag and SREG updates. It sits between the instruction fetch/decode stage and the I/O bus, and stalls fetch while a bit operation is in flight.

---
 rtl/bit_op_sequencer_pkg.sv | 50 +++++
 rtl/bit_op_sequencer_decode.sv | 32 +++
 rtl/bit_op_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bit_op_sequencer_pkg.sv
// Shared definitions for the bit set/clear sequencer: state and operation-class
// encodings plus the opcode match patterns used by the decoder.
package bit_op_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_RD   = 3'd2,
        ST_MOD  = 3'd3,
        ST_WR   = 3'd4,
        ST_TEST = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_SBI  = 4'd1,
        OP_CBI  = 4'd2,
        OP_SBIC = 4'd3,
        OP_SBIS = 4'd4,
        OP_BST  = 4'd5,
        OP_BLD  = 4'd6,
        OP_BSET = 4'd7,
        OP_BCLR = 4'd8
    } op_t;

    // Opcode patterns as mask/value pairs; masked-out bits are operand fields.
    localparam logic [15:0] C_IO_MASK   = 16'hFF00;
    localparam logic [15:0] C_SBI       = 16'h9A00;
    localparam logic [15:0] C_CBI       = 16'h9800;
    localparam logic [15:0] C_SBIC      = 16'h9900;
    localparam logic [15:0] C_SBIS      = 16'h9B00;
    localparam logic [15:0] C_TBIT_MASK = 16'hFE08;
    localparam logic [15:0] C_BST       = 16'hFA00;
    localparam logic [15:0] C_BLD       = 16'hF800;
    localparam logic [15:0] C_SREG_MASK = 16'hFF8F;
    localparam logic [15:0] C_BSET      = 16'h9408;
    localparam logic [15:0] C_BCLR      = 16'h9488;

    function automatic logic op_match(input logic [15:0] word,
                                      input logic [15:0] mask,
                                      input logic [15:0] pattern);
        return (word & mask) == pattern;
    endfunction

    // Classes that go through the I/O bus read phase.
    function automatic logic is_io_op(input op_t op);
        return (op == OP_SBI) || (op == OP_CBI) || (op == OP_SBIC) || (op == OP_SBIS);
    endfunction

endpackage

// File: rtl/bit_op_sequencer_decode.sv
// Combinational instruction-word to operation-class decoder. Kept free of state
// so fetch-side stall logic can reuse it on the raw instruction word.
module bit_op_sequencer_decode
    import bit_op_sequencer_pkg::*;
(
    input  logic [15:0] i_ir,
    output op_t         o_op
);

    // Priority match of the instruction word against the bit-operation patterns
    always_comb begin
        o_op = OP_NONE;
        if (op_match(i_ir, C_IO_MASK, C_SBI)) begin
            o_op = OP_SBI;
        end else if (op_match(i_ir, C_IO_MASK, C_CBI)) begin
            o_op = OP_CBI;
        end else if (op_match(i_ir, C_IO_MASK, C_SBIC)) begin
            o_op = OP_SBIC;
        end else if (op_match(i_ir, C_IO_MASK, C_SBIS)) begin
            o_op = OP_SBIS;
        end else if (op_match(i_ir, C_TBIT_MASK, C_BST)) begin
            o_op = OP_BST;
        end else if (op_match(i_ir, C_TBIT_MASK, C_BLD)) begin
            o_op = OP_BLD;
        end else if (op_match(i_ir, C_SREG_MASK, C_BSET)) begin
            o_op = OP_BSET;
        end else if (op_match(i_ir, C_SREG_MASK, C_BCLR)) begin
            o_op = OP_BCLR;
        end
    end

endmodule

// File: rtl/bit_op_sequencer.sv
// Multi-cycle sequencer for AVR bit set/clear instructions. Holds the
// instruction word for the external datapath, runs I/O read-modify-write for
// SBI/CBI, evaluates SBIC/SBIS skips and issues RF/T/SREG write strobes.
//
// state   | meaning
// ST_IDLE | ready for a new instruction
// ST_EXEC | single-cycle commit of BLD/BST/BSET/BCLR/NONE
// ST_RD   | I/O read strobe issued
// ST_MOD  | read data valid, datapath result captured into wdata
// ST_WR   | I/O write-back of modified byte, retire
// ST_TEST | skip evaluation for SBIC/SBIS, retire
module bit_op_sequencer
    import bit_op_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_valid,
    input  logic [15:0] ir,
    output logic        ready,
    input  logic        kill,
    output logic [15:0] bsc_ir,
    input  logic [7:0]  bsc_ro,
    input  logic        bst_tf,
    output logic [4:0]  io_addr,
    output logic        io_re,
    input  logic [7:0]  io_rdata,
    output logic        io_we,
    output logic [7:0]  io_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        tf_we,
    output logic        tf_wdata,
    output logic        sreg_we,
    output logic [7:0]  sreg_wdata,
    output logic        done,
    output logic        skip
);

    state_t      r_state;
    state_t      w_next_state;
    op_t         r_op;
    op_t         w_op;
    logic [15:0] r_ir;
    logic [7:0]  r_wdata;
    logic        w_accept;
    logic        w_test_bit;

    bit_op_sequencer_decode u_decode (
        .i_ir (ir),
        .o_op (w_op)
    );

    assign ready      = (r_state == ST_IDLE);
    assign w_accept   = ir_valid && ready && !kill;
    assign bsc_ir     = r_ir;
    assign io_addr    = r_ir[7:3];
    assign rf_waddr   = r_ir[8:4];
    assign io_wdata   = r_wdata;
    assign w_test_bit = io_rdata[r_ir[2:0]];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the instruction word and its class when an operation is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= 16'h0000;
            r_op <= OP_NONE;
        end else if (w_accept) begin
            r_ir <= ir;
            r_op <= w_op;
        end
    end

    // Latch the modified byte while read data is on the bus so WR drives a stable value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdata <= 8'h00;
        end else if (r_state == ST_MOD) begin
            r_wdata <= bsc_ro;
        end
    end

    // Next-state logic; kill only aborts the phases before anything is committed
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = is_io_op(w_op) ? ST_RD : ST_EXEC;
                end
            end
            ST_EXEC: w_next_state = ST_IDLE;
            ST_RD: begin
                if (kill) begin
                    w_next_state = ST_IDLE;
                end else if ((r_op == OP_SBIC) || (r_op == OP_SBIS)) begin
                    w_next_state = ST_TEST;
                end else begin
                    w_next_state = ST_MOD;
                end
            end
            ST_MOD:  w_next_state = kill ? ST_IDLE : ST_WR;
            ST_WR:   w_next_state = ST_IDLE;
            ST_TEST: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Strobe and retire decode from the registered state and held class
    always_comb begin
        io_re      = 1'b0;
        io_we      = 1'b0;
        rf_we      = 1'b0;
        rf_wdata   = 8'h00;
        tf_we      = 1'b0;
        tf_wdata   = 1'b0;
        sreg_we    = 1'b0;
        sreg_wdata = 8'h00;
        done       = 1'b0;
        skip       = 1'b0;
        unique case (r_state)
            ST_EXEC: begin
                done = 1'b1;
                case (r_op)
                    OP_BLD: begin
                        rf_we    = 1'b1;
                        rf_wdata = bsc_ro;
                    end
                    OP_BST: begin
                        tf_we    = 1'b1;
                        tf_wdata = bst_tf;
                    end
                    OP_BSET, OP_BCLR: begin
                        sreg_we    = 1'b1;
                        sreg_wdata = bsc_ro;
                    end
                    default: ;
                endcase
            end
            ST_RD: io_re = 1'b1;
            ST_WR: begin
                io_we = 1'b1;
                done  = 1'b1;
            end
            ST_TEST: begin
                if (!kill) begin
                    done = 1'b1;
                    skip = (r_op == OP_SBIS) ? w_test_bit : ~w_test_bit;
                end
            end
            default: ;
        endcase
    end

endmodule
